// File: rtl/kmc_npr_pkg.sv
// kmc_npr_pkg: shared types and constants for the KMC11 NPR (DMA) engine.
//   npr_state_e      - transfer sequencer states
//   NPR_TIMEOUT_DEF  - default clocks allowed without bus acknowledge
//   NPR_ADDR_W       - Unibus address width
//   NPR_DATA_W       - Unibus data width
package kmc_npr_pkg;

    localparam int unsigned NPR_TIMEOUT_DEF = 64;
    localparam int unsigned NPR_ADDR_W      = 18;
    localparam int unsigned NPR_DATA_W      = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_RELEASE = 2'd2
    } npr_state_e;

endpackage : kmc_npr_pkg

// File: rtl/kmc_npr.sv
// kmc_npr: KMC11 non-processor-request engine. Runs one Unibus DATI/DATO
// cycle per microcode GO strobe and reports a missing acknowledge as NXM.
//   clk, rst          - clock and asynchronous active-low reset
//   kmcINIT           - synchronous initialize (same effect as reset)
//   kmcNPRGO          - start strobe, honoured only while idle
//   kmcNPROUT/BYTE    - direction (1 = DATO) and byte flag at GO
//   kmcNPRBA/kmcBAEO  - bus address bits 15:0 / 17:16 at GO
//   kmcNPRDATO        - write data at GO
//   kmcNPRDATI        - read data from the last successful DATI
//   kmcNPRBUSY        - transfer in progress
//   kmcSETNXM         - one-cycle pulse when the request times out
//   devREQO/devACKI   - bus request / acknowledge handshake
//   devADDRO/WRO/BYTEO/DATAO - latched transfer fields
//   devDATAI          - bus read data, valid while devACKI is high
module kmc_npr
    import kmc_npr_pkg::*;
#(
    parameter int unsigned TIMEOUT = NPR_TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  kmcINIT,
    input  logic                  kmcNPRGO,
    input  logic                  kmcNPROUT,
    input  logic                  kmcNPRBYTE,
    input  logic [15:0]           kmcNPRBA,
    input  logic [1:0]            kmcBAEO,
    input  logic [NPR_DATA_W-1:0] kmcNPRDATO,
    output logic [NPR_DATA_W-1:0] kmcNPRDATI,
    output logic                  kmcNPRBUSY,
    output logic                  kmcSETNXM,
    output logic                  devREQO,
    input  logic                  devACKI,
    output logic [NPR_ADDR_W-1:0] devADDRO,
    output logic                  devWRO,
    output logic                  devBYTEO,
    output logic [NPR_DATA_W-1:0] devDATAO,
    input  logic [NPR_DATA_W-1:0] devDATAI
);

    localparam int unsigned       CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    npr_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q,   cnt_d;
    logic                  req_q,   req_d;
    logic                  busy_q,  busy_d;
    logic                  nxm_q,   nxm_d;
    logic [NPR_ADDR_W-1:0] addr_q,  addr_d;
    logic                  wr_q,    wr_d;
    logic                  byte_q,  byte_d;
    logic [NPR_DATA_W-1:0] dato_q,  dato_d;
    logic [NPR_DATA_W-1:0] dati_q,  dati_d;

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        busy_d  = busy_q;
        nxm_d   = 1'b0;
        addr_d  = addr_q;
        wr_d    = wr_q;
        byte_d  = byte_q;
        dato_d  = dato_q;
        dati_d  = dati_q;

        if (kmcINIT) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            req_d   = 1'b0;
            busy_d  = 1'b0;
            addr_d  = '0;
            wr_d    = 1'b0;
            byte_d  = 1'b0;
            dato_d  = '0;
            dati_d  = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (kmcNPRGO) begin
                        addr_d  = {kmcBAEO, kmcNPRBA};
                        wr_d    = kmcNPROUT;
                        byte_d  = kmcNPRBYTE;
                        dato_d  = kmcNPRDATO;
                        cnt_d   = '0;
                        req_d   = 1'b1;
                        busy_d  = 1'b1;
                        state_d = ST_REQ;
                    end
                end
                ST_REQ: begin
                    // Acknowledge takes priority over an expiring timeout
                    if (devACKI) begin
                        req_d   = 1'b0;
                        state_d = ST_RELEASE;
                        if (!wr_q) begin
                            if (!byte_q) begin
                                dati_d = devDATAI;
                            end else if (addr_q[0]) begin
                                dati_d = {8'h00, devDATAI[15:8]};
                            end else begin
                                dati_d = {8'h00, devDATAI[7:0]};
                            end
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        req_d   = 1'b0;
                        busy_d  = 1'b0;
                        nxm_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    // Slave must drop its acknowledge; no timeout here
                    if (!devACKI) begin
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    req_d   = 1'b0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            nxm_q   <= 1'b0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            byte_q  <= 1'b0;
            dato_q  <= '0;
            dati_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            nxm_q   <= nxm_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            byte_q  <= byte_d;
            dato_q  <= dato_d;
            dati_q  <= dati_d;
        end
    end

    assign kmcNPRDATI = dati_q;
    assign kmcNPRBUSY = busy_q;
    assign kmcSETNXM  = nxm_q;
    assign devREQO    = req_q;
    assign devADDRO   = addr_q;
    assign devWRO     = wr_q;
    assign devBYTEO   = byte_q;
    assign devDATAO   = dato_q;

endmodule : kmc_npr

// File: doc/kmc_npr.md
# kmc_npr

KMC11 non-processor-request (DMA) engine. Performs one 16-bit or 8-bit Unibus DATI/DATO cycle per microcode request. The 18-bit bus address is formed from microcode-supplied bits 15:0 and MISC register bits 3:2 (BAEO). A missing bus acknowledge is reported to the MISC register on `kmcSETNXM`, which sets MISC bit 0.

## Interface
- TIMEOUT, 64: clocks `devREQO` may stay asserted without `devACKI` before NXM is declared; legal range 2..4095.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; one clock, asynchronous and active-low.
- kmcINIT  in  1  synchronous initialize; same effect as reset.
- kmcNPRGO  in  1  one-cycle start strobe from microcode.
- kmcNPROUT  in  1  direction at GO: 1 = DATO (write), 0 = DATI (read).
- kmcNPRBYTE  in  1  byte transfer at GO.
- kmcNPRBA  in  16  bus address bits 15:0 at GO.
- kmcBAEO  in  2  bus address bits 17:16 (MISC bits 3:2) at GO.
- kmcNPRDATO  in  16  write data at GO.
- kmcNPRDATI  out  16  read data from the last successful DATI.
- kmcNPRBUSY  out  1  transfer in progress.
- kmcSETNXM  out  1  one-cycle pulse on timeout; drives the MISC NXM set input.
- devREQO  out  1  bus request.
- devACKI  in  1  bus acknowledge, synchronous to clk.
- devADDRO  out  18  latched bus address.
- devWRO  out  1  latched direction.
- devBYTEO  out  1  latched byte flag.
- devDATAO  out  16  latched write data.
- devDATAI  in  16  bus read data; valid while `devACKI` is high.

## Operation
- States: IDLE, REQ, RELEASE.
- **IDLE**
  - `kmcNPRGO` latches `{kmcBAEO, kmcNPRBA}`, direction, byte flag and write data into the dev* output registers.
  - It also clears the timeout counter and moves to REQ.
- **REQ**
  - `devREQO` = 1 and the counter increments each cycle.
  - If `devACKI` = 1, go to RELEASE. On DATI, capture read data at the same edge.
  - Else if counter == TIMEOUT-1, go to IDLE and pulse `kmcSETNXM` for one cycle.
- **RELEASE**
  - `devREQO` = 0.
  - Wait for `devACKI` = 0, then go to IDLE. This phase has no timeout.
- **Read data capture (DATI)**
  - Word: `kmcNPRDATI` = `devDATAI`.
  - Byte, even address: {8'h00, `devDATAI`[7:0]}.
  - Byte, odd address: {8'h00, `devDATAI`[15:8]}.
- **Write data (DATO):** `devDATAO` is driven unchanged. The slave selects the byte lane from `devADDRO`[0].
- `kmcNPRBUSY` = 1 in REQ and RELEASE, 0 in IDLE.
- **Boundary conditions**
  - `kmcNPRGO` outside IDLE is ignored; latched fields are unchanged.
  - `devACKI` high in the same cycle the counter reaches TIMEOUT-1: ack wins; no NXM.
  - NXM abort leaves `kmcNPRDATI` unchanged.
  - `kmcNPRDATI` is unchanged after any DATO.
  - `kmcINIT` or reset in any state: go to IDLE immediately, `devREQO` drops, no `kmcSETNXM` pulse.
  - `devACKI` high while IDLE is ignored.
  - Address wraps nowhere: every transfer is a single cycle, with no auto-increment.
- **Reset values:** all outputs 0; `kmcNPRDATI` = 0; `devADDRO` = 0.

## Timing
- GO sampled at edge n: `devREQO` and dev* outputs valid after edge n; `kmcNPRBUSY` high from n.
- `devACKI` sampled high at edge m:
  - `devREQO` low after m;
  - `kmcNPRDATI` updated after m.
- `devACKI` sampled low at edge k ≥ m+1: `kmcNPRBUSY` low after k. The next GO is accepted at k+1.
- **Timeout:** with no ack, `devREQO` is high for exactly TIMEOUT cycles. `kmcSETNXM` is high in the cycle after `devREQO` falls, and `kmcNPRBUSY` falls together with `devREQO`.
- All outputs are registered; no combinational input-to-output paths.

## Structure
- Package `kmc_npr_pkg`: state enum (IDLE, REQ, RELEASE), default TIMEOUT constant, and the address-width localparam (18).
- Counter width is $clog2(TIMEOUT).
- Single flat module. No sub-module is warranted; the timeout counter is inline.

## Test plan
- **DATI word:** GO with BA=16'o1000, BAEO=2'b01, OUT=0. Ack after 3 cycles with `devDATAI`=16'h1234. Required: `devADDRO`=18'o201000, `kmcNPRDATI`=16'h1234, BUSY drops one cycle after ack is released.
- **DATI byte, odd address:** BA=16'o1001, `devDATAI`=16'hABCD. Required: `kmcNPRDATI`=16'h00AB.
- **DATO:** OUT=1, `kmcNPRDATO`=16'hBEEF. Ack after 1 cycle. Required: `devWRO`=1, `devDATAO`=16'hBEEF, `kmcNPRDATI` unchanged, no NXM.
- **Timeout (TIMEOUT=64), no ack:** required: `devREQO` high exactly 64 cycles, one-cycle `kmcSETNXM`, `kmcNPRDATI` unchanged. A second case with ack on the 64th REQ cycle must complete normally with no NXM.
- **GO while busy:** GO with a different BA during REQ. Required: `devADDRO` unchanged and the original transfer completes.
- **kmcINIT mid-REQ, then asynchronous reset mid-RELEASE:**
  - INIT: next cycle `devREQO`=0, BUSY=0, no NXM.
  - Reset: all outputs 0 immediately on rst low.
